// File: rtl/imm_encoder.sv
// Two-stage RISC-V instruction encoder: stage 1 captures the request fields plus
// the immediate range check, stage 2 assembles the 32-bit word and its error flag.
module imm_encoder #(
    parameter int unsigned ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_format,
    input  logic [4:0]               in_opcode,
    input  logic [4:0]               in_rd,
    input  logic [4:0]               in_rs1,
    input  logic [4:0]               in_rs2,
    input  logic [2:0]               in_funct3,
    input  logic [6:0]               in_funct7,
    input  logic [31:0]              in_imm,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic                     out_err,
    input  logic                     err_clr,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    typedef enum logic [2:0] {
        FMT_I   = 3'd0,
        FMT_ISH = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5
    } fmt_e;

    logic                     s1_valid_q, s1_valid_d;
    logic [2:0]               s1_fmt_q;
    logic [4:0]               s1_op_q, s1_rd_q, s1_rs1_q, s1_rs2_q;
    logic [2:0]               s1_f3_q;
    logic [6:0]               s1_f7_q;
    logic [31:0]              s1_imm_q;
    logic                     s1_err_q, s1_err_d;

    logic                     s2_valid_q, s2_valid_d;
    logic [31:0]              s2_instr_q, s2_instr_d;
    logic                     s2_err_q;

    logic [ERR_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                     s1_ld, s2_ld;

    // A stage may load when it is empty or its contents move on this cycle.
    assign s2_ld    = !s2_valid_q || out_ready;
    assign s1_ld    = !s1_valid_q || s2_ld;
    assign in_ready = s1_ld;

    assign s1_valid_d = s1_ld ? in_valid : s1_valid_q;
    assign s2_valid_d = s2_ld ? s1_valid_q : s2_valid_q;

    always_comb begin
        s1_err_d = 1'b1;
        case (in_format)
            FMT_I, FMT_S: s1_err_d = in_imm[31:11] != {21{in_imm[11]}};
            FMT_ISH:      s1_err_d = in_imm[31:5] != '0;
            FMT_B:        s1_err_d = (in_imm[31:12] != {20{in_imm[12]}}) || in_imm[0];
            FMT_U:        s1_err_d = in_imm[11:0] != '0;
            FMT_J:        s1_err_d = (in_imm[31:20] != {12{in_imm[20]}}) || in_imm[0];
            default:      s1_err_d = 1'b1;
        endcase
    end

    always_comb begin
        s2_instr_d = '0;
        case (s1_fmt_q)
            FMT_I:   s2_instr_d = {s1_imm_q[11:0], s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q, 2'b11};
            FMT_ISH: s2_instr_d = {s1_f7_q, s1_imm_q[4:0], s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q, 2'b11};
            FMT_S:   s2_instr_d = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_f3_q, s1_imm_q[4:0],
                                   s1_op_q, 2'b11};
            FMT_B:   s2_instr_d = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_f3_q,
                                   s1_imm_q[4:1], s1_imm_q[11], s1_op_q, 2'b11};
            FMT_U:   s2_instr_d = {s1_imm_q[31:12], s1_rd_q, s1_op_q, 2'b11};
            FMT_J:   s2_instr_d = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                                   s1_rd_q, s1_op_q, 2'b11};
            default: s2_instr_d = '0;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (err_clr) begin
            cnt_d = '0;
        end else if (out_valid && out_ready && out_err && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_fmt_q   <= '0;
            s1_op_q    <= '0;
            s1_rd_q    <= '0;
            s1_rs1_q   <= '0;
            s1_rs2_q   <= '0;
            s1_f3_q    <= '0;
            s1_f7_q    <= '0;
            s1_imm_q   <= '0;
            s1_err_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_instr_q <= '0;
            s2_err_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            cnt_q      <= cnt_d;
            if (s1_ld && in_valid) begin
                s1_fmt_q <= in_format;
                s1_op_q  <= in_opcode;
                s1_rd_q  <= in_rd;
                s1_rs1_q <= in_rs1;
                s1_rs2_q <= in_rs2;
                s1_f3_q  <= in_funct3;
                s1_f7_q  <= in_funct7;
                s1_imm_q <= in_imm;
                s1_err_q <= s1_err_d;
            end
            if (s2_ld && s1_valid_q) begin
                s2_instr_q <= s2_instr_d;
                s2_err_q   <= s1_err_q;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out_instr = s2_instr_q;
    assign out_err   = s2_err_q;
    assign err_count = cnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: directed vector table, backpressure and reset sequences,
// then randomized traffic scored against an arithmetic reference model.
module tb_imm_encoder;

    localparam int unsigned CW = 3;

    logic          clk = 1'b0;
    logic          rst_n, in_valid, in_ready, out_valid, out_ready, out_err, err_clr;
    logic [2:0]    in_format, in_funct3;
    logic [4:0]    in_opcode, in_rd, in_rs1, in_rs2;
    logic [6:0]    in_funct7;
    logic [31:0]   in_imm, out_instr;
    logic [CW-1:0] err_count;

    int total = 0;
    int bad   = 0;

    imm_encoder #(.ERR_CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_format(in_format), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_err(out_err), .err_clr(err_clr), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  fmt;
        logic [4:0]  op, rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] exp_instr;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        in_format = v.fmt; in_opcode = v.op; in_rd = v.rd; in_rs1 = v.rs1;
        in_rs2 = v.rs2; in_funct3 = v.f3; in_funct7 = v.f7; in_imm = v.imm;
    endtask

    // Reference: range rules as signed intervals, fields placed by shift-and-mask.
    function automatic logic [32:0] model(input vec_t v);
        longint      s  = longint'($signed(v.imm));
        logic [31:0] w  = 32'h0;
        logic        e  = 1'b1;
        logic [31:0] im = v.imm;
        logic [31:0] base = (32'(v.op) << 2) | 32'h3;
        case (v.fmt)
            3'd0: begin e = (s < -2048) || (s > 2047);
                  w = ((im & 32'hFFF) << 20) | (32'(v.rs1) << 15) | (32'(v.f3) << 12) | (32'(v.rd) << 7); end
            3'd1: begin e = im > 32'd31;
                  w = (32'(v.f7) << 25) | ((im & 32'h1F) << 20) | (32'(v.rs1) << 15) | (32'(v.f3) << 12) | (32'(v.rd) << 7); end
            3'd2: begin e = (s < -2048) || (s > 2047);
                  w = (((im >> 5) & 32'h7F) << 25) | (32'(v.rs2) << 20) | (32'(v.rs1) << 15) | (32'(v.f3) << 12) | ((im & 32'h1F) << 7); end
            3'd3: begin e = (s < -4096) || (s > 4095) || (im % 2 != 0);
                  w = (((im >> 12) & 1) << 31) | (((im >> 5) & 32'h3F) << 25) | (32'(v.rs2) << 20) | (32'(v.rs1) << 15)
                      | (32'(v.f3) << 12) | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 1) << 7); end
            3'd4: begin e = (im % 4096) != 0;
                  w = (im & 32'hFFFFF000) | (32'(v.rd) << 7); end
            3'd5: begin e = (s < -(64'sd1 << 20)) || (s >= (64'sd1 << 20)) || (im % 2 != 0);
                  w = (((im >> 20) & 1) << 31) | (((im >> 1) & 32'h3FF) << 21) | (((im >> 11) & 1) << 20)
                      | (im & 32'h000FF000) | (32'(v.rd) << 7); end
            default: begin e = 1'b1; w = 32'h0; end
        endcase
        if (v.fmt <= 3'd5) w = w | base;
        return {e, w};
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        int   m = $urandom_range(0, 3);
        v.name = "rnd";
        v.fmt = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
        v.op = 5'($urandom); v.rd = 5'($urandom); v.rs1 = 5'($urandom); v.rs2 = 5'($urandom);
        v.f3 = 3'($urandom); v.f7 = 7'($urandom);
        case (m)
            0: v.imm = $urandom;
            1: v.imm = 32'($urandom_range(0, 10000)) - 32'd5000;
            2: v.imm = $urandom & 32'hFFFFF000;
            default: v.imm = 32'($urandom_range(0, 4194304)) - 32'd2097152;
        endcase
        v.exp_instr = 32'h0; v.exp_err = 1'b0;
        return v;
    endfunction

    vec_t        tbl[10];
    vec_t        bp[3];
    vec_t        rv;
    logic [32:0] exp_q[$];
    logic [32:0] e;
    int          cnt_m;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
        in_format = '0; in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_funct3 = '0; in_funct7 = '0; in_imm = '0;

        tbl[0] = '{"I_neg1",   3'd0, 5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,    32'hFFFFFFFF, 32'hFFF00093, 1'b0};
        tbl[1] = '{"B_8",      3'd3, 5'b11000, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,    32'h00000008, 32'h00000463, 1'b0};
        tbl[2] = '{"B_odd",    3'd3, 5'b11000, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,    32'h00000007, 32'h00000363, 1'b1};
        tbl[3] = '{"U_ok",     3'd4, 5'b01101, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0,    32'h12345000, 32'h123452B7, 1'b0};
        tbl[4] = '{"U_low",    3'd4, 5'b01101, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0,    32'h12345001, 32'h123452B7, 1'b1};
        tbl[5] = '{"J_800",    3'd5, 5'b11011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,    32'h00000800, 32'h001000EF, 1'b0};
        tbl[6] = '{"fmt6",     3'd6, 5'b11011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,    32'h00000800, 32'h00000000, 1'b1};
        tbl[7] = '{"ISH_7",    3'd1, 5'b00100, 5'd3, 5'd4, 5'd0, 3'd5, 7'h20,   32'h00000007, 32'h40725193, 1'b0};
        tbl[8] = '{"ISH_32",   3'd1, 5'b00100, 5'd3, 5'd4, 5'd0, 3'd5, 7'h20,   32'h00000020, 32'h40025193, 1'b1};
        tbl[9] = '{"S_neg4",   3'd2, 5'b01000, 5'd0, 5'd2, 5'd3, 3'd2, 7'd0,    32'hFFFFFFFC, 32'hFE312E23, 1'b0};

        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk); rst_n = 1'b1;

        cnt_m = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(tbl[i]); in_valid = 1'b1; out_ready = 1'b1;
            #3 chk({tbl[i].name, "_in_ready"}, 32'(in_ready), 32'd1);
            @(posedge clk); #1 in_valid = 1'b0;
            chk({tbl[i].name, "_early_valid"}, 32'(out_valid), 32'd0);
            @(posedge clk); #1;
            chk({tbl[i].name, "_valid"}, 32'(out_valid), 32'd1);
            chk({tbl[i].name, "_instr"}, out_instr, tbl[i].exp_instr);
            chk({tbl[i].name, "_err"}, 32'(out_err), 32'(tbl[i].exp_err));
            if (tbl[i].exp_err && cnt_m != 7) cnt_m++;
            @(posedge clk); #1;
            chk({tbl[i].name, "_err_count"}, 32'(err_count), 32'(cnt_m));
        end

        // err_clr coinciding with an errored consume must leave zero.
        @(negedge clk);
        drive(tbl[4]); in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1 err_clr = 1'b1;
        chk("clr_prio_valid", 32'(out_valid & out_err), 32'd1);
        @(posedge clk); #1 err_clr = 1'b0;
        chk("clr_prio_count", 32'(err_count), 32'd0);
        cnt_m = 0;

        // Backpressure: two accepts fill the pipe, third word waits.
        for (int k = 0; k < 3; k++) begin
            bp[k] = '{"bp", 3'd4, 5'b01101, 5'(k + 1), 5'd0, 5'd0, 3'd0, 7'd0,
                      32'h11111000 * 32'(k + 1), 32'h0, 1'b0};
        end
        begin
            int acc = 0;
            int got = 0;
            out_ready = 1'b0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                in_valid = (acc < 3);
                if (acc < 3) drive(bp[acc]);
                #3;
                if (c >= 2) begin
                    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
                    e = model(bp[0]);
                    chk("bp_hold_instr", out_instr, e[31:0]);
                    chk("bp_hold_valid", 32'(out_valid), 32'd1);
                end
                if (in_valid && in_ready) acc++;
            end
            chk("bp_accepts", 32'(acc), 32'd2);
            for (int c = 0; c < 12 && got < 3; c++) begin
                @(negedge clk);
                out_ready = 1'b1;
                in_valid = (acc < 3);
                if (acc < 3) drive(bp[acc]);
                #3;
                if (out_valid) begin
                    e = model(bp[got]);
                    chk("bp_order_instr", out_instr, e[31:0]);
                    got++;
                end
                if (in_valid && in_ready) acc++;
            end
            chk("bp_all_delivered", 32'(got), 32'd3);
        end

        // Randomized traffic against the queue model.
        begin
            logic        stall = 1'b0;
            logic [31:0] p_instr = '0;
            logic        p_err = 1'b0;
            for (int c = 0; c < 600; c++) begin
                @(negedge clk);
                rv = rand_vec();
                drive(rv);
                in_valid = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 3) != 0);
                err_clr = ($urandom_range(0, 60) == 0);
                #3;
                if (stall) begin
                    chk("rnd_stable_instr", out_instr, p_instr);
                    chk("rnd_stable_err", 32'(out_err), 32'(p_err));
                end
                chk("rnd_in_ready", 32'(in_ready), 32'((exp_q.size() < 2) || out_ready));
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("rnd_spurious_word", 32'(out_valid), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rnd_instr", out_instr, e[31:0]);
                        chk("rnd_err", 32'(out_err), 32'(e[32]));
                        if (!err_clr && out_err && cnt_m != 7) cnt_m++;
                    end
                end
                if (err_clr) cnt_m = 0;
                if (in_valid && in_ready) exp_q.push_back(model(rv));
                stall = out_valid && !out_ready;
                p_instr = out_instr; p_err = out_err;
                @(posedge clk); #1;
                chk("rnd_err_count", 32'(err_count), 32'(cnt_m));
            end
            err_clr = 1'b0;
            @(negedge clk);
            in_valid = 1'b0; out_ready = 1'b1;
            for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
                #3;
                if (out_valid) begin
                    e = exp_q.pop_front();
                    chk("drain_instr", out_instr, e[31:0]);
                end
                @(negedge clk);
            end
            chk("drain_empty", 32'(exp_q.size()), 32'd0);
        end

        // Reset with two words in flight.
        @(negedge clk);
        drive(tbl[4]); in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 in_valid = 1'b0;
        chk("rmid_two_in_flight", 32'(out_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rmid_out_valid", 32'(out_valid), 32'd0);
        chk("rmid_out_instr", out_instr, 32'h0);
        chk("rmid_err_count", 32'(err_count), 32'd0);
        chk("rmid_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("rmid_no_stale", 32'(out_valid), 32'd0);
            chk("rmid_ready_after", 32'(in_ready), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
